mac_accumulate: RTL and testbench

Downstream accumulation stage for the 16-bit Wallace tree `multiplier`. It accepts operand pairs over a valid/ready handshake and drives the registered operands into the combinational multiplier. It registers the 32-bit product `{out2,out1}` and sums a group of products, terminated by `in_last`, into an unsigned saturating accumulator. The result is presented on an output valid/ready handshake.

---
 rtl/mac_accumulate.sv | 89 ++++++++
 tb/tb_mac_accumulate.sv | 140 ++++++++++++++
 2 files changed

// File: rtl/mac_accumulate.sv
// mac_accumulate: registers operands for an external 16x16 multiplier and sums
// the products of each in_last-terminated group into a saturating accumulator.
module mac_accumulate #(
    parameter int ACC_W = 40
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             in_last,
    input  logic [15:0]      a,
    input  logic [15:0]      b,
    output logic [15:0]      mul_a,
    output logic [15:0]      mul_b,
    input  logic [15:0]      mul_lo,
    input  logic [15:0]      mul_hi,
    output logic [ACC_W-1:0] acc_out,
    output logic             sat,
    output logic             out_valid,
    input  logic             out_ready
);
    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] ACC   = 2'd1;
    localparam logic [1:0] FLUSH = 2'd2;
    localparam logic [1:0] DONE  = 2'd3;

    logic [1:0]       state_q, state_d;
    logic             in_ready_q, out_valid_q;
    logic [15:0]      mul_a_q, mul_b_q;
    logic             v1_q, l1_q, v2_q, l2_q;
    logic [31:0]      prod_q;
    logic [ACC_W-1:0] acc_q, acc_d;
    logic             sat_q, sat_d;
    logic [ACC_W:0]   sum;
    logic             accept, release_out, ovf;

    assign accept      = in_valid && in_ready_q;
    assign release_out = (state_q == DONE) && out_ready;
    assign sum         = {1'b0, acc_q} + {{(ACC_W - 31){1'b0}}, prod_q};
    assign ovf         = sum[ACC_W] || sat_q;

    always_comb begin
        state_d = accept ? (in_last ? FLUSH : ACC)
                : (state_q == FLUSH && v2_q && l2_q) ? DONE
                : release_out ? IDLE : state_q;
        acc_d   = release_out ? '0 : v2_q ? (ovf ? {ACC_W{1'b1}} : sum[ACC_W-1:0]) : acc_q;
        sat_d   = release_out ? 1'b0 : v2_q ? ovf : sat_q;
    end

    // in_ready and out_valid are registered copies of what the next state implies
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            in_ready_q  <= 1'b0;
            out_valid_q <= 1'b0;
            mul_a_q     <= '0;
            mul_b_q     <= '0;
            v1_q        <= 1'b0;
            l1_q        <= 1'b0;
            v2_q        <= 1'b0;
            l2_q        <= 1'b0;
            prod_q      <= '0;
            acc_q       <= '0;
            sat_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            in_ready_q  <= (state_d == IDLE) || (state_d == ACC);
            out_valid_q <= state_d == DONE;
            if (accept) begin
                mul_a_q <= a;
                mul_b_q <= b;
            end
            v1_q        <= accept;
            l1_q        <= accept && in_last;
            v2_q        <= v1_q;
            l2_q        <= l1_q;
            if (v1_q) prod_q <= {mul_hi, mul_lo};
            acc_q       <= acc_d;
            sat_q       <= sat_d;
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign mul_a     = mul_a_q;
    assign mul_b     = mul_b_q;
    assign acc_out   = acc_q;
    assign sat       = sat_q;
endmodule

// File: tb/tb_mac_accumulate.sv
// tb_mac_accumulate: drives 40-bit and 33-bit instances in lockstep and checks
// group results against plain-arithmetic saturating sums.
module tb_mac_accumulate;
    logic clk = 1'b0, rst_n = 1'b0;
    logic in_valid = 1'b0, in_last = 1'b0, out_ready = 1'b0;
    logic [15:0] a = '0, b = '0;

    logic        rdy_w, rdy_n, ov_w, ov_n, sat_w, sat_n;
    logic [15:0] ma_w, mb_w, ma_n, mb_n;
    logic [39:0] acc_w;
    logic [32:0] acc_n;
    logic [31:0] p_w, p_n;

    assign p_w = ma_w * mb_w;
    assign p_n = ma_n * mb_n;

    mac_accumulate #(.ACC_W(40)) dut_w (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(rdy_w), .in_last(in_last),
        .a(a), .b(b), .mul_a(ma_w), .mul_b(mb_w), .mul_lo(p_w[15:0]), .mul_hi(p_w[31:16]),
        .acc_out(acc_w), .sat(sat_w), .out_valid(ov_w), .out_ready(out_ready));

    mac_accumulate #(.ACC_W(33)) dut_n (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(rdy_n), .in_last(in_last),
        .a(a), .b(b), .mul_a(ma_n), .mul_b(mb_n), .mul_lo(p_n[15:0]), .mul_hi(p_n[31:16]),
        .acc_out(acc_n), .sat(sat_n), .out_valid(ov_n), .out_ready(out_ready));

    always #5 clk = ~clk;

    int total = 0, bad = 0;
    logic [15:0] qa[$], qb[$];

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [63:0] sat_sum(input longint unsigned s, input int w);
        longint unsigned lim = (64'd1 << w) - 1;
        return (s > lim) ? lim : s;
    endfunction

    task automatic run_group(input bit gaps, input int hold);
        longint unsigned s = 0;
        logic [39:0] hw;
        logic [32:0] hn;
        for (int i = 0; i < qa.size(); i++) begin
            if (gaps) repeat ($urandom_range(0, 2)) begin
                in_valid = 1'b0;
                a = 16'($urandom);
                out_ready = 1'($urandom);
                @(negedge clk);
            end
            in_valid = 1'b1; a = qa[i]; b = qb[i]; in_last = (i == qa.size() - 1);
            out_ready = 1'($urandom);
            chk("rdy_beat", {62'd0, rdy_w, rdy_n}, 64'd3);
            s += longint'(qa[i]) * longint'(qb[i]);
            @(negedge clk);
        end
        in_valid = 1'b0; in_last = 1'b0; a = 16'($urandom); b = 16'($urandom);
        chk("rdy_after_last", {62'd0, rdy_w, rdy_n}, 64'd0);
        chk("ov_e0", {62'd0, ov_w, ov_n}, 64'd0);
        @(negedge clk);
        chk("ov_e1", {62'd0, ov_w, ov_n}, 64'd0);
        out_ready = 1'b0;
        @(negedge clk);
        chk("ov_e2", {62'd0, ov_w, ov_n}, 64'd3);
        chk("acc40", 64'(acc_w), sat_sum(s, 40));
        chk("sat40", 64'(sat_w), 64'(s > 64'hFF_FFFF_FFFF));
        chk("acc33", 64'(acc_n), sat_sum(s, 33));
        chk("sat33", 64'(sat_n), 64'(s > 64'h1_FFFF_FFFF));
        hw = acc_w; hn = acc_n;
        repeat (hold) begin
            in_valid = 1'b1; in_last = 1'($urandom); a = 16'($urandom); b = 16'($urandom);
            @(negedge clk);
            chk("hold_ov", {62'd0, ov_w, ov_n}, 64'd3);
            chk("hold_rdy", {62'd0, rdy_w, rdy_n}, 64'd0);
            chk("hold_acc", {acc_w[30:0], acc_n}, {hw[30:0], hn});
        end
        out_ready = 1'b1;
        @(negedge clk);
        in_valid = 1'b0; in_last = 1'b0; out_ready = 1'b0;
        chk("hs_ov", {62'd0, ov_w, ov_n}, 64'd0);
        chk("hs_rdy", {62'd0, rdy_w, rdy_n}, 64'd3);
        chk("hs_clr", {acc_w[30:0], acc_n, sat_w}, 65'd0);
        qa.delete(); qb.delete();
    endtask

    initial begin
        #12;
        chk("rst_rdy", {62'd0, rdy_w, rdy_n}, 64'd0);
        chk("rst_out", {acc_w, ov_w, sat_w}, 42'd0);
        @(negedge clk);
        rst_n = 1'b1;
        chk("rel_rdy0", {62'd0, rdy_w, rdy_n}, 64'd0);
        @(negedge clk);
        chk("rel_rdy1", {62'd0, rdy_w, rdy_n}, 64'd3);

        qa = '{16'd7}; qb = '{16'd7};
        run_group(1'b0, 0);
        qa = '{16'hFFFF, 16'hFFFF, 16'hFFFF, 16'hFFFF}; qb = qa;
        run_group(1'b0, 5);
        qa = '{16'hFFFF, 16'hFFFF, 16'hFFFF}; qb = qa;
        run_group(1'b0, 1);
        qa = '{16'd3}; qb = '{16'd5};
        run_group(1'b0, 0);
        qa = '{16'd0, 16'hFFFF, 16'd0}; qb = '{16'hFFFF, 16'd0, 16'd0};
        run_group(1'b1, 2);

        // abandon a group halfway through with an asynchronous reset
        for (int i = 0; i < 2; i++) begin
            in_valid = 1'b1; a = 16'hFFFF; b = 16'hFFFF; in_last = 1'b0;
            @(negedge clk);
        end
        #2 rst_n = 1'b0;
        #1;
        chk("mid_rst_rdy", {62'd0, rdy_w, rdy_n}, 64'd0);
        chk("mid_rst_out", {acc_w, ov_w, sat_w, ma_w, mb_w}, 74'd0);
        in_valid = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        qa = '{16'd2}; qb = '{16'd3};
        run_group(1'b0, 0);

        for (int g = 0; g < 40; g++) begin
            int n = $urandom_range(1, 8);
            for (int i = 0; i < n; i++) begin
                qa.push_back(($urandom_range(0, 3) == 0) ? 16'hFFFF : 16'($urandom));
                qb.push_back(($urandom_range(0, 5) == 0) ? 16'h0 : 16'($urandom));
            end
            run_group(1'($urandom), $urandom_range(0, 4));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
